// File: rtl/atwd_ped_subtract.sv
// -----------------------------------------------------------------------------
// atwd_ped_subtract
//   Read side of the ATWD pedestal RAM (512 x 10 bit, 4 channels x 128 samples).
//   Streams one ATWD channel waveform, drives the pedestal RAM read address for
//   every sample, subtracts the stored pedestal, adds PED_OFFSET and saturates
//   the result to the DATA_W unsigned range.
//
// Ports
//   clock, reset        system clock (shared with the RAM), async active-high reset
//   enable, start, chan start a waveform on chan (IDLE only, enable must be 1)
//   in_valid/in_ready   raw sample stream, in_data is the raw sample
//   ped_rdaddress       RAM read address {chan, idx}; RAM q (ped_q) is 1 cycle later
//   out_valid/out_ready corrected sample stream, out_data / out_last
//   busy, done          busy from accepted start until done; done pulses on the
//                       handshake of the last output sample
//   sat_count           clamped samples in the current waveform, sticks at 255
//   state_dbg           current FSM state (IDLE=0, RUN=1, DRAIN=2)
//
// Handshake: a transfer happens on a rising clock edge where valid & ready are
// both 1. A producer holding valid high keeps its data stable until that edge;
// ready may depend combinationally on the consumer state but never on valid.
// -----------------------------------------------------------------------------
module atwd_ped_subtract #(
   parameter int DATA_W     = 10,
   parameter int ADDR_W     = 9,
   parameter int SAMPLES    = 128,
   parameter int PED_OFFSET = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              start,
   input  logic [1:0]        chan,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ped_rdaddress,
   input  logic [DATA_W-1:0] ped_q,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [7:0]        sat_count,
   output logic [1:0]        state_dbg
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int AW    = DATA_W + 2;
   localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(SAMPLES - 1);
   localparam logic signed [AW-1:0] OFFSET  = AW'(PED_OFFSET);
   localparam logic signed [AW-1:0] MAX_VAL = AW'((1 << DATA_W) - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        chan_q, chan_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              clear_sat;

   // Stage 1: raw sample waiting for its pedestal word from the RAM.
   logic              s1_valid_q;
   logic              s1_last_q;
   logic [DATA_W-1:0] s1_data_q;
   logic [ADDR_W-1:0] s1_addr_q;

   // Output register.
   logic              out_valid_q;
   logic              out_last_q;
   logic [DATA_W-1:0] out_data_q;
   logic [7:0]        sat_q;

   logic              adv;
   logic              in_ready_c;
   logic              accept;
   logic              done_c;
   logic signed [AW-1:0] diff;
   logic [DATA_W-1:0] clamped;
   logic              clamp_hit;

   // ---------------------------------------------------------------- handshake
   always_comb begin
      adv        = !out_valid_q || out_ready;
      in_ready_c = (state_q == S_RUN) && (!s1_valid_q || adv);
      accept     = in_valid && in_ready_c;
      done_c     = (state_q == S_DRAIN) && out_valid_q && out_ready && out_last_q;
      // While stage 1 is stalled the RAM keeps re-reading the word of the
      // sample it holds, so ped_q stays matched to s1_data_q.
      ped_rdaddress = accept ? {chan_q, idx_q} : s1_addr_q;
   end

   // ---------------------------------------------------------------- arithmetic
   always_comb begin
      diff      = $signed({2'b00, s1_data_q}) - $signed({2'b00, ped_q}) + OFFSET;
      clamped   = diff[DATA_W-1:0];
      clamp_hit = 1'b0;
      if (diff[AW-1]) begin
         clamped   = '0;
         clamp_hit = 1'b1;
      end else if (diff > MAX_VAL) begin
         clamped   = '1;
         clamp_hit = 1'b1;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         chan_q  <= 2'd0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      chan_d    = chan_q;
      idx_d     = idx_q;
      clear_sat = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && enable) begin
               state_d   = S_RUN;
               chan_d    = chan;
               idx_d     = '0;
               clear_sat = 1'b1;
            end
         end
         S_RUN: begin
            if (accept) begin
               // idx stops at the last sample instead of wrapping.
               if (idx_q == IDX_MAX) state_d = S_DRAIN;
               else                  idx_d   = idx_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (done_c) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- pipeline
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_data_q  <= '0;
         s1_addr_q  <= '0;
      end else if (accept) begin
         s1_valid_q <= 1'b1;
         s1_last_q  <= (idx_q == IDX_MAX);
         s1_data_q  <= in_data;
         s1_addr_q  <= {chan_q, idx_q};
      end else if (adv) begin
         s1_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (adv) begin
         out_valid_q <= s1_valid_q;
         out_last_q  <= s1_valid_q && s1_last_q;
         if (s1_valid_q) out_data_q <= clamped;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sat_q <= 8'd0;
      end else if (clear_sat) begin
         sat_q <= 8'd0;
      end else if (s1_valid_q && adv && clamp_hit && (sat_q != 8'hFF)) begin
         sat_q <= sat_q + 8'd1;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_c;
   assign sat_count = sat_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_atwd_ped_subtract.sv
// -----------------------------------------------------------------------------
// tb_atwd_ped_subtract
//   Two instances share every input: u_dut0 with PED_OFFSET=0 and u_dut1 with
//   PED_OFFSET=1000. Each has its own registered pedestal RAM model reading a
//   common ped_mem. Expected samples are computed from the raw sample and
//   ped_mem at the moment a sample is accepted and queued per instance.
// -----------------------------------------------------------------------------
module tb_atwd_ped_subtract;

   localparam int DW = 10;
   localparam int AW = 9;
   localparam int NS = 128;
   localparam int MAXV = (1 << DW) - 1;

   logic          clock     = 1'b0;
   logic          reset     = 1'b1;
   logic          enable    = 1'b0;
   logic          start     = 1'b0;
   logic [1:0]    chan      = 2'd0;
   logic          in_valid  = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic          out_ready = 1'b0;

   logic          in_ready0, in_ready1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] ped_q0, ped_q1;
   logic          out_valid0, out_valid1;
   logic [DW-1:0] out_data0, out_data1;
   logic          out_last0, out_last1;
   logic          busy0, busy1;
   logic          done0, done1;
   logic [7:0]    sat0, sat1;
   logic [1:0]    st0, st1;

   logic [DW-1:0] ped_mem [0:511];
   int            wave_in [0:NS-1];
   logic [DW:0]   exp0_q[$];
   logic [DW:0]   exp1_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int nsat [2];
   int tab_sat [2];
   int tab_first0;

   typedef struct {
      logic [1:0] chan;
      int         ped_kind;   // 0: a[6:0], 1: 500, 2: 0, 3: random
      int         in_val;     // -1: random
      int         rdy;
      int         vld;
      int         first0;     // -1: not checked
      int         sat0;
      int         sat1;
   } vec_t;
   vec_t vecs [6];

   // ---------------------------------------------------------------- clock/reset
   always #5 clock = ~clock;

   always @(posedge clock) begin
      ped_q0 <= ped_mem[addr0];
      ped_q1 <= ped_mem[addr1];
   end

   atwd_ped_subtract #(.PED_OFFSET(0)) u_dut0 (
      .clock(clock), .reset(reset), .enable(enable), .start(start), .chan(chan),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
      .ped_rdaddress(addr0), .ped_q(ped_q0),
      .out_valid(out_valid0), .out_data(out_data0), .out_last(out_last0),
      .out_ready(out_ready), .busy(busy0), .done(done0), .sat_count(sat0),
      .state_dbg(st0)
   );

   atwd_ped_subtract #(.PED_OFFSET(1000)) u_dut1 (
      .clock(clock), .reset(reset), .enable(enable), .start(start), .chan(chan),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
      .ped_rdaddress(addr1), .ped_q(ped_q1),
      .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1),
      .out_ready(out_ready), .busy(busy1), .done(done1), .sat_count(sat1),
      .state_dbg(st1)
   );

   // ---------------------------------------------------------------- helpers
   task automatic chk(input string name, input int g, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d expected %0d", name, g, act, exp);
      end
   endtask

   function automatic int clampv(input int x);
      if (x < 0)    return 0;
      if (x > MAXV) return MAXV;
      return x;
   endfunction

   task automatic check_reset_vals(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk({tag, "_in_ready"},  g, (g != 0) ? in_ready1  : in_ready0,  0);
         chk({tag, "_out_valid"}, g, (g != 0) ? out_valid1 : out_valid0, 0);
         chk({tag, "_out_data"},  g, (g != 0) ? out_data1  : out_data0,  0);
         chk({tag, "_out_last"},  g, (g != 0) ? out_last1  : out_last0,  0);
         chk({tag, "_busy"},      g, (g != 0) ? busy1      : busy0,      0);
         chk({tag, "_done"},      g, (g != 0) ? done1      : done0,      0);
         chk({tag, "_sat_count"}, g, (g != 0) ? sat1       : sat0,       0);
         chk({tag, "_rdaddress"}, g, (g != 0) ? addr1      : addr0,      0);
      end
   endtask

   task automatic prep(input int kind, input int in_val);
      for (int a = 0; a < 512; a++) begin
         case (kind)
            0:       ped_mem[a] = DW'(a % 128);
            1:       ped_mem[a] = DW'(500);
            2:       ped_mem[a] = '0;
            default: ped_mem[a] = DW'($urandom_range(MAXV));
         endcase
      end
      for (int k = 0; k < NS; k++)
         wave_in[k] = (in_val < 0) ? int'($urandom_range(MAXV)) : in_val;
   endtask

   // ---------------------------------------------------------------- driver + scoreboard
   task automatic run_wave(input logic [1:0] c, input int rdy, input int vld,
                           input int glitch_at, input int reset_at,
                           input bit start_in_done, input bit en_run);
      int            acc, cyc, d, v;
      bit            fin, acc_now, empty;
      bit            first_seen [2];
      bit            exp_done [2];
      logic [AW-1:0] last_addr, exp_addr, ad;
      logic          ir, ov, ol, bz, dn;
      logic [DW-1:0] od;
      logic [7:0]    sc;
      logic [DW:0]   e;

      @(negedge clock);
      enable    = 1'b1;
      start     = 1'b1;
      chan      = c;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("idle_busy",      g, (g != 0) ? busy1      : busy0,      0);
         chk("idle_in_ready",  g, (g != 0) ? in_ready1  : in_ready0,  0);
         chk("idle_out_valid", g, (g != 0) ? out_valid1 : out_valid0, 0);
      end
      exp0_q.delete();
      exp1_q.delete();
      nsat       = '{0, 0};
      first_seen = '{0, 0};
      acc        = 0;
      cyc        = 0;
      fin        = 1'b0;
      last_addr  = '0;

      while (!fin && cyc < 4000) begin
         @(negedge clock);
         start     = (cyc == glitch_at);
         chan      = start ? ~c : c;
         enable    = en_run;
         in_valid  = (acc < NS) && ($urandom_range(99) < vld);
         in_data   = DW'(wave_in[(acc < NS) ? acc : NS-1]);
         out_ready = ($urandom_range(99) < rdy);
         #1;
         acc_now  = in_valid && in_ready0;
         exp_addr = {c, 7'(acc)};
         if (acc_now) begin
            d = int'(in_data) - int'(ped_mem[exp_addr]);
            for (int g = 0; g < 2; g++) begin
               v = clampv(d + g * 1000);
               if (v != d + g * 1000) nsat[g]++;
               e = {acc == NS-1, DW'(v)};
               if (g == 0) exp0_q.push_back(e);
               else        exp1_q.push_back(e);
            end
         end
         for (int g = 0; g < 2; g++) begin
            ir = (g != 0) ? in_ready1  : in_ready0;
            ad = (g != 0) ? addr1      : addr0;
            ov = (g != 0) ? out_valid1 : out_valid0;
            od = (g != 0) ? out_data1  : out_data0;
            ol = (g != 0) ? out_last1  : out_last0;
            bz = (g != 0) ? busy1      : busy0;
            dn = (g != 0) ? done1      : done0;
            sc = (g != 0) ? sat1       : sat0;
            if (acc >= NS) chk("in_ready_drain", g, ir, 0);
            if (acc_now)      chk("rdaddress", g, ad, exp_addr);
            else if (acc > 0) chk("rdaddress_hold", g, ad, last_addr);
            exp_done[g] = 1'b0;
            if (ov && out_ready) begin
               empty = (g == 0) ? (exp0_q.size() == 0) : (exp1_q.size() == 0);
               if (empty) begin
                  chk("out_unexpected", g, ov, 0);
               end else begin
                  e = (g == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                  chk("out_data", g, od, e[DW-1:0]);
                  chk("out_last", g, ol, e[DW]);
                  exp_done[g] = e[DW];
                  if (!first_seen[g]) begin
                     first_seen[g] = 1'b1;
                     if (g == 0 && tab_first0 >= 0) chk("first_out", g, od, tab_first0);
                  end
               end
            end
            chk("done", g, dn, exp_done[g]);
            chk("busy", g, bz, 1);
            if (exp_done[g]) begin
               chk("sat_count", g, sc, (nsat[g] > 255) ? 255 : nsat[g]);
               if (tab_sat[g] >= 0) chk("sat_table", g, sc, tab_sat[g]);
            end
         end
         if (acc_now) begin
            last_addr = exp_addr;
            acc++;
         end
         fin = exp_done[0] && exp_done[1];
         if (fin) start = start_in_done;
         if (reset_at >= 0 && acc == reset_at) begin
            reset = 1'b1;
            #1;
            check_reset_vals("midrst");
            @(negedge clock);
            reset    = 1'b0;
            start    = 1'b0;
            in_valid = 1'b0;
            return;
         end
         cyc++;
      end
      chk("wave_timeout", 0, fin, 1);
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check_reset_vals("por");
      @(negedge clock);
      reset = 1'b0;

      vecs[0] = '{2'd2, 0, 200, 100, 100, 200,   0, 128};
      vecs[1] = '{2'd1, 1, 100, 100, 100,   0, 128,   0};
      vecs[2] = '{2'd0, 2, 600, 100, 100, 600,   0, 128};
      vecs[3] = '{2'd2, 0, 200,  50,  50, 200,   0, 128};
      vecs[4] = '{2'd3, 3,  -1,  70,  80,  -1,  -1,  -1};
      vecs[5] = '{2'd1, 3,  -1,  30, 100,  -1,  -1,  -1};

      for (int i = 0; i < 6; i++) begin
         prep(vecs[i].ped_kind, vecs[i].in_val);
         tab_first0 = vecs[i].first0;
         tab_sat[0] = vecs[i].sat0;
         tab_sat[1] = vecs[i].sat1;
         run_wave(vecs[i].chan, vecs[i].rdy, vecs[i].vld, -1, -1, 1'b0, 1'b1);
      end

      // start with another chan while running; enable low while running
      prep(0, 200);
      tab_first0 = 200;
      tab_sat    = '{0, 128};
      run_wave(2'd2, 100, 100, 10, -1, 1'b0, 1'b0);

      // enable=0 in IDLE blocks start
      @(negedge clock);
      enable = 1'b0;
      start  = 1'b1;
      chan   = 2'd3;
      @(negedge clock);
      start = 1'b0;
      #1;
      chk("en0_busy", 0, busy0, 0);
      chk("en0_busy", 1, busy1, 0);
      chk("en0_in_ready", 0, in_ready0, 0);
      repeat (3) @(negedge clock);
      #1;
      chk("en0_busy_later", 0, busy0, 0);

      // reset at sample 60, then a full waveform from idx 0
      prep(3, -1);
      tab_first0 = -1;
      tab_sat    = '{-1, -1};
      run_wave(2'd1, 80, 80, -1, 60, 1'b0, 1'b1);
      #1;
      chk("post_rst_done", 0, done0, 0);
      run_wave(2'd1, 100, 100, -1, -1, 1'b0, 1'b1);

      // back-to-back: start in the done cycle is ignored, next cycle accepted
      prep(1, 100);
      tab_first0 = 0;
      tab_sat    = '{128, 0};
      run_wave(2'd0, 100, 100, -1, -1, 1'b1, 1'b1);
      prep(2, 600);
      tab_first0 = 600;
      tab_sat    = '{0, 128};
      run_wave(2'd0, 100, 100, -1, -1, 1'b0, 1'b1);

      @(negedge clock);
      start = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
